// File: rtl/ptw_axi_read_master_if.sv
// ---------------------------------------------------------------------------
// ptw_axi_read_master_if
//   AXI4-Lite read-channel bundle (AR + R) between the PTE fetch master and
//   the memory fabric.
//
//   Handshake: a transfer occurs on a rising clock edge where VALID and READY
//   are both high. Once VALID is raised, the source holds VALID and its
//   payload stable until that edge. READY may change freely, and a source
//   never waits for READY before raising VALID.
//
//   Signals:
//     M_ARADDR  / M_ARPROT / M_ARVALID  master -> slave  read address
//     M_ARREADY                         slave  -> master address accept
//     M_RDATA   / M_RRESP  / M_RVALID   slave  -> master read data/response
//     M_RREADY                          master -> slave  data accept
// ---------------------------------------------------------------------------
interface ptw_axi_read_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] M_ARADDR;
    logic [2:0]            M_ARPROT;
    logic                  M_ARVALID;
    logic                  M_ARREADY;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;
    logic                  M_RVALID;
    logic                  M_RREADY;

    modport master (
        output M_ARADDR, M_ARPROT, M_ARVALID, M_RREADY,
        input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );

    modport slave (
        input  M_ARADDR, M_ARPROT, M_ARVALID, M_RREADY,
        output M_ARREADY, M_RDATA, M_RRESP, M_RVALID
    );
endinterface

// File: rtl/ptw_axi_read_master.sv
// ---------------------------------------------------------------------------
// ptw_axi_read_master
//   Single-outstanding AXI4-Lite read master for the I-TLB page-table walker.
//   A walker request is turned into one AR/R transaction; the PTE comes back
//   as a one-cycle DATA_FROM_AXIM_VALID pulse. Requests while BUSY are
//   dropped (no queueing). FLUSH during a walk lets the bus transaction
//   complete but suppresses its return pulse.
//
//   Optional build macro: PTW_TIMEOUT_EN
//     When defined, R_WAIT is bounded by TIMEOUT_CYCLES; on expiry the block
//     returns a zero PTE with BUS_ERROR set.
//
//   Ports:
//     CLK, RST                 clock, synchronous active-high reset
//     FLUSH                    TLB flush, cancels in-flight return
//     ADDR_TO_AXIM_VALID/ADDR  walker request strobe and PTE address
//     BUSY                     request capture .. return cycle inclusive
//     DATA_FROM_AXIM_VALID     one-cycle PTE return pulse
//     DATA_FROM_AXIM           PTE word (held between pulses)
//     BUS_ERROR                one-cycle pulse with the return on error
//     m_axi                    AXI4-Lite read channels (master side)
//     DBG_STATE                current FSM state, for observation only
// ---------------------------------------------------------------------------
module ptw_axi_read_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  ADDR_TO_AXIM_VALID,
    input  logic [ADDR_WIDTH-1:0] ADDR_TO_AXIM,
    output logic                  BUSY,
    output logic                  DATA_FROM_AXIM_VALID,
    output logic [DATA_WIDTH-1:0] DATA_FROM_AXIM,
    output logic                  BUS_ERROR,
    ptw_axi_read_master_if.master m_axi,
    output logic [1:0]            DBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_AR_WAIT = 2'd1,
        S_R_WAIT  = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  dval_q;
    logic                  berr_q;
    logic                  drop_q;
    logic                  accept;
    logic                  r_hs;
    logic                  timeout_hit;
    logic                  deliver;

    // A flush seen in the same cycle as the R handshake still cancels.
    assign deliver = !(drop_q || FLUSH);
    assign accept  = (state_q == S_IDLE) && ADDR_TO_AXIM_VALID && !FLUSH;
    assign r_hs    = (state_q == S_R_WAIT) && m_axi.M_RVALID;

`ifdef PTW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = (state_q == S_R_WAIT) && !m_axi.M_RVALID &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == S_R_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_AR_WAIT;
            S_AR_WAIT: if (m_axi.M_ARREADY) state_d = S_R_WAIT;
            S_R_WAIT:  if (r_hs || timeout_hit) state_d = S_RETURN;
            S_RETURN:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs: handshake strobes decode from the state register only, so no
    // input reaches M_ARVALID or M_RREADY combinationally.
    always_comb begin
        m_axi.M_ARVALID      = 1'b0;
        m_axi.M_RREADY       = 1'b0;
        BUSY                 = 1'b1;
        case (state_q)
            S_IDLE:    BUSY = 1'b0;
            S_AR_WAIT: m_axi.M_ARVALID = 1'b1;
            S_R_WAIT:  m_axi.M_RREADY  = 1'b1;
            default:   BUSY = 1'b1;
        endcase
        m_axi.M_ARADDR       = araddr_q;
        m_axi.M_ARPROT       = 3'b101;
        DATA_FROM_AXIM       = data_q;
        DATA_FROM_AXIM_VALID = dval_q;
        BUS_ERROR            = berr_q;
        DBG_STATE            = state_q;
    end

    // Datapath: address capture, return registers and drop flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            araddr_q <= '0;
            data_q   <= '0;
            dval_q   <= 1'b0;
            berr_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            dval_q <= 1'b0;
            berr_q <= 1'b0;

            if (accept) begin
                araddr_q <= ADDR_TO_AXIM;
            end

            if (state_q == S_RETURN) begin
                drop_q <= 1'b0;
            end else if (FLUSH && ((state_q == S_AR_WAIT) || (state_q == S_R_WAIT))) begin
                drop_q <= 1'b1;
            end

            if (r_hs) begin
                // An error response returns an invalid PTE (V bit clear).
                data_q <= (m_axi.M_RRESP == 2'b00) ? m_axi.M_RDATA : '0;
                dval_q <= deliver;
                berr_q <= deliver && (m_axi.M_RRESP != 2'b00);
            end else if (timeout_hit) begin
                data_q <= '0;
                dval_q <= deliver;
                berr_q <= deliver;
            end
        end
    end

endmodule

// File: tb/tb_ptw_axi_read_master.sv
module tb_ptw_axi_read_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        ADDR_TO_AXIM_VALID;
  logic [31:0] ADDR_TO_AXIM;
  logic        BUSY;
  logic        DATA_FROM_AXIM_VALID;
  logic [31:0] DATA_FROM_AXIM;
  logic        BUS_ERROR;
  logic [1:0]  DBG_STATE;

  ptw_axi_read_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) axi ();

  ptw_axi_read_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .ADDR_TO_AXIM_VALID(ADDR_TO_AXIM_VALID), .ADDR_TO_AXIM(ADDR_TO_AXIM),
    .BUSY(BUSY), .DATA_FROM_AXIM_VALID(DATA_FROM_AXIM_VALID),
    .DATA_FROM_AXIM(DATA_FROM_AXIM), .BUS_ERROR(BUS_ERROR),
    .m_axi(axi), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          ar_hs = 0;
  bit          saw_1000 = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // monitor: bus events observed mid-cycle
  always @(negedge CLK) begin
    if (!RST) begin
      if (axi.M_ARVALID && axi.M_ARREADY) ar_hs++;
      if (DATA_FROM_AXIM_VALID) got_q.push_back(DATA_FROM_AXIM);
      if (axi.M_ARVALID && axi.M_ARADDR == 32'h0000_1000) saw_1000 = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // driver: one walker request with the bench acting as AXI slave.
  // Expectations come straight from the read rules: a flush anywhere in the
  // walk cancels the pulse; an error response returns a zero PTE.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [1:0] rresp, input int ar_lat, input int r_lat,
                         input bit flush_r, input bit busy_req);
    logic        exp_v;
    logic        exp_e;
    logic [31:0] exp_d;
    int          ar_hi;
    int          r_hi;
    exp_v = !flush_r;
    exp_e = exp_v && (rresp != 2'b00);
    exp_d = (rresp == 2'b00) ? rdata : 32'h0;
    ar_hi = 0;
    r_hi  = 0;

    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM       = addr;
    step();
    ADDR_TO_AXIM_VALID = 1'b0;
    ADDR_TO_AXIM       = $urandom;
    for (int i = 0; i < ar_lat; i++) begin
      @(negedge CLK);
      if (axi.M_ARVALID && axi.M_ARADDR === addr) ar_hi++;
      step();
    end
    axi.M_ARREADY = 1'b1;
    @(negedge CLK);
    if (axi.M_ARVALID && axi.M_ARADDR === addr) ar_hi++;
    chk("busy_in_ar", BUSY, 1);
    step();
    axi.M_ARREADY = 1'b0;
    chk("ar_stable_cycles", ar_hi, ar_lat + 1);

    FLUSH = flush_r;
    if (busy_req) begin
      ADDR_TO_AXIM_VALID = 1'b1;
      ADDR_TO_AXIM       = 32'h0000_1000;
    end
    for (int i = 0; i < r_lat; i++) begin
      @(negedge CLK);
      if (axi.M_RREADY) r_hi++;
      step();
      FLUSH = 1'b0;
      ADDR_TO_AXIM_VALID = 1'b0;
    end
    axi.M_RVALID = 1'b1;
    axi.M_RDATA  = rdata;
    axi.M_RRESP  = rresp;
    @(negedge CLK);
    if (axi.M_RREADY) r_hi++;
    step();
    axi.M_RVALID = 1'b0;
    axi.M_RDATA  = $urandom;
    axi.M_RRESP  = 2'b00;
    FLUSH = 1'b0;
    ADDR_TO_AXIM_VALID = 1'b0;
    chk("rready_cycles", r_hi, r_lat + 1);

    @(negedge CLK);
    chk("ret_valid", DATA_FROM_AXIM_VALID, exp_v);
    chk("ret_error", BUS_ERROR, exp_e);
    chk("ret_busy", BUSY, 1);
    chk("ret_rready", axi.M_RREADY, 0);
    if (exp_v) begin
      chk("ret_data", DATA_FROM_AXIM, exp_d);
      exp_q.push_back(exp_d);
    end
    step();
    @(negedge CLK);
    chk("idle_busy", BUSY, 0);
    chk("idle_valid", DATA_FROM_AXIM_VALID, 0);
    chk("idle_error", BUS_ERROR, 0);
  endtask

  initial begin
    int          hs0;
    logic [31:0] a;
    logic [1:0]  rr;
    RST = 1'b1;
    FLUSH = 1'b0;
    ADDR_TO_AXIM_VALID = 1'b0;
    ADDR_TO_AXIM = '0;
    axi.M_ARREADY = 1'b0;
    axi.M_RDATA = '0;
    axi.M_RRESP = 2'b00;
    axi.M_RVALID = 1'b0;
    repeat (3) step();

    // reset state
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", DATA_FROM_AXIM_VALID, 0);
    chk("rst_data", DATA_FROM_AXIM, 0);
    chk("rst_error", BUS_ERROR, 0);
    chk("rst_araddr", axi.M_ARADDR, 0);
    chk("rst_arprot", axi.M_ARPROT, 3'b101);
    chk("rst_arvalid", axi.M_ARVALID, 0);
    chk("rst_rready", axi.M_RREADY, 0);
    chk("rst_state", DBG_STATE, 0);
    RST = 1'b0;
    step();

    // basic read with minimum latency
    do_read(32'h003E_8004, 32'h0000_40CF, 2'b00, 0, 0, 1'b0, 1'b0);

    // backpressure: ARREADY after 3 cycles, RVALID after 5
    do_read(32'h0040_1008, 32'h1234_5671, 2'b00, 3, 5, 1'b0, 1'b0);

    // busy drop: request to 0x1000 while in R_WAIT
    hs0 = ar_hs;
    do_read(32'h0050_0010, 32'h0BAD_CAF1, 2'b00, 1, 2, 1'b0, 1'b1);
    repeat (3) begin
      step();
      @(negedge CLK);
    end
    chk("busy_drop_ar_count", ar_hs - hs0, 1);
    chk("busy_drop_addr_seen", saw_1000, 0);

    // bus error: SLVERR with all-ones data
    do_read(32'h0060_0020, 32'hFFFF_FFFF, 2'b10, 0, 1, 1'b0, 1'b0);

    // flush after the AR handshake, then a normal read
    do_read(32'h0070_0030, 32'h0000_00CF, 2'b00, 0, 2, 1'b1, 1'b0);
    do_read(32'h0070_0034, 32'h0000_01CF, 2'b00, 0, 0, 1'b0, 1'b0);

    // flush coincident with RVALID
    do_read(32'h0070_0038, 32'h0000_02CF, 2'b00, 1, 0, 1'b1, 1'b0);

    // flush with a request in IDLE: ignored
    FLUSH = 1'b1;
    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM = 32'h0080_0000;
    step();
    FLUSH = 1'b0;
    ADDR_TO_AXIM_VALID = 1'b0;
    @(negedge CLK);
    chk("idle_flush_busy", BUSY, 0);
    chk("idle_flush_arvalid", axi.M_ARVALID, 0);

    // reset mid-operation in AR_WAIT
    ADDR_TO_AXIM_VALID = 1'b1;
    ADDR_TO_AXIM = 32'h0090_0000;
    step();
    ADDR_TO_AXIM_VALID = 1'b0;
    @(negedge CLK);
    chk("pre_rst_arvalid", axi.M_ARVALID, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_arvalid", axi.M_ARVALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    do_read(32'h0000_2000, 32'h0000_2001, 2'b00, 0, 1, 1'b0, 1'b0);

    // randomized reads
    for (int n = 0; n < 20; n++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_read(a, $urandom, rr, $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

`ifdef PTW_TIMEOUT_EN
    begin
      int  rw;
      bit  seen;
      rw = 0;
      seen = 1'b0;
      ADDR_TO_AXIM_VALID = 1'b1;
      ADDR_TO_AXIM = 32'h00A0_0000;
      axi.M_ARREADY = 1'b1;
      step();
      ADDR_TO_AXIM_VALID = 1'b0;
      step();
      axi.M_ARREADY = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
        @(negedge CLK);
        if (DATA_FROM_AXIM_VALID) begin
          seen = 1'b1;
          chk("timeout_error", BUS_ERROR, 1);
          chk("timeout_data", DATA_FROM_AXIM, 0);
          exp_q.push_back(32'h0);
        end else if (axi.M_RREADY) begin
          rw++;
        end
        step();
      end
      chk("timeout_seen", seen, 1);
      chk("timeout_rwait_cycles", rw, 16);
      axi.M_RVALID = 1'b1;
      step();
      axi.M_RVALID = 1'b0;
      @(negedge CLK);
      chk("late_rvalid_ignored", DATA_FROM_AXIM_VALID, 0);
    end
`endif

    // scoreboard
    repeat (2) step();
    chk("pulse_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("pulse_data", got_q[i], exp_q[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
